// File: rtl/wide_to_narrow_serializer.sv
// wide_to_narrow_serializer: captures a wide word on start and emits it as OUT_W chunks,
// advancing one chunk per downstream tx_done acknowledge.
module wide_to_narrow_serializer #(
    parameter int IN_W      = 64,
    parameter int OUT_W     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  data_in,
    input  logic             start,
    input  logic             tx_done,
    input  logic             abort,
    output logic [OUT_W-1:0] data_out,
    output logic             tx_enable,
    output logic             busy,
    output logic             word_done
);
    localparam int NUM = IN_W / OUT_W;
    localparam int CW = $clog2(NUM);
    localparam logic [CW-1:0] LAST = CW'(NUM - 1);

    generate
        if (IN_W % OUT_W != 0 || NUM < 2) begin : g_bad_params
            $error("IN_W must be a multiple of OUT_W giving at least two chunks");
        end
    endgenerate

    typedef enum logic {IDLE, WAIT} state_t;

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [IN_W-1:0]  cap, cap_n;
    logic [OUT_W-1:0] data_n;
    logic             txe_n, busy_n, done_n;

    function automatic logic [OUT_W-1:0] chunk(input logic [IN_W-1:0] w, input logic [CW-1:0] k);
        int sel;
        sel = MSB_FIRST ? NUM - 1 - int'(k) : int'(k);
        return w[sel*OUT_W +: OUT_W];
    endfunction

    // abort outranks everything; data_out is left holding whatever chunk was last shown
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        cap_n   = cap;
        data_n  = data_out;
        txe_n   = 1'b0;
        busy_n  = busy;
        done_n  = 1'b0;
        if (abort) begin
            state_n = IDLE;
            cnt_n   = '0;
            busy_n  = 1'b0;
        end else if (state == IDLE) begin
            if (start) begin
                state_n = WAIT;
                cap_n   = data_in;
                cnt_n   = '0;
                data_n  = chunk(data_in, '0);
                txe_n   = 1'b1;
                busy_n  = 1'b1;
            end
        end else if (tx_done) begin
            if (cnt == LAST) begin
                state_n = IDLE;
                busy_n  = 1'b0;
                done_n  = 1'b1;
            end else begin
                cnt_n  = cnt + 1'b1;
                data_n = chunk(cap, cnt + 1'b1);
                txe_n  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            cap       <= '0;
            data_out  <= '0;
            tx_enable <= 1'b0;
            busy      <= 1'b0;
            word_done <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            cap       <= cap_n;
            data_out  <= data_n;
            tx_enable <= txe_n;
            busy      <= busy_n;
            word_done <= done_n;
        end
    end
endmodule

// File: tb/tb_wide_to_narrow_serializer.sv
// tb_wide_to_narrow_serializer: three serializer configurations share one control stream;
// a per-instance reference model queues expected chunks and a monitor checks every cycle.
module tb_wide_to_narrow_serializer;
    localparam int NUMS[3] = '{8, 8, 2};
    localparam int OWS[3]  = '{8, 8, 16};
    localparam bit MSBS[3] = '{1'b1, 1'b0, 1'b1};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        tx_done = 1'b0;
    logic        abort = 1'b0;
    logic [63:0] d = '0;
    logic [31:0] d2 = '0;
    logic [7:0]  do0, do1;
    logic [15:0] do2;
    logic [2:0]  txe, bsy, wdn;
    logic [63:0] dout [3];

    wide_to_narrow_serializer u0 (
        .clk(clk), .rst_n(rst_n), .data_in(d), .start(start), .tx_done(tx_done), .abort(abort),
        .data_out(do0), .tx_enable(txe[0]), .busy(bsy[0]), .word_done(wdn[0])
    );
    wide_to_narrow_serializer #(.IN_W(64), .OUT_W(8), .MSB_FIRST(1'b0)) u1 (
        .clk(clk), .rst_n(rst_n), .data_in(d), .start(start), .tx_done(tx_done), .abort(abort),
        .data_out(do1), .tx_enable(txe[1]), .busy(bsy[1]), .word_done(wdn[1])
    );
    wide_to_narrow_serializer #(.IN_W(32), .OUT_W(16), .MSB_FIRST(1'b1)) u2 (
        .clk(clk), .rst_n(rst_n), .data_in(d2), .start(start), .tx_done(tx_done), .abort(abort),
        .data_out(do2), .tx_enable(txe[2]), .busy(bsy[2]), .word_done(wdn[2])
    );

    assign dout[0] = 64'(do0);
    assign dout[1] = 64'(do1);
    assign dout[2] = 64'(do2);

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    bit          m_busy [3];
    bit          m_txe [3];
    bit          m_wd [3];
    int          k [3];
    logic [63:0] word [3];
    logic [63:0] exp_mem [3][64];
    int          wr [3];
    int          rd [3];
    logic [63:0] log_q [3];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_chunk(input int i, input logic [63:0] w, input int kk);
        int sh;
        sh = MSBS[i] ? (NUMS[i] - 1 - kk) * OWS[i] : kk * OWS[i];
        return (w >> sh) & ((64'd1 << OWS[i]) - 64'd1);
    endfunction

    task automatic push(input int i);
        exp_mem[i][wr[i] % 64] = ref_chunk(i, word[i], k[i]);
        wr[i]++;
        m_txe[i] = 1'b1;
    endtask

    // drive one cycle of inputs and predict each instance's outputs after the coming edge
    task automatic step(input bit st, input logic [63:0] dd, input logic [31:0] dd2, input bit txd, input bit ab);
        start = st;
        d = dd;
        d2 = dd2;
        tx_done = txd;
        abort = ab;
        for (int i = 0; i < 3; i++) begin
            m_txe[i] = 1'b0;
            m_wd[i] = 1'b0;
            if (ab) begin
                m_busy[i] = 1'b0;
            end else if (!m_busy[i]) begin
                if (st) begin
                    word[i] = (i == 2) ? 64'(dd2) : dd;
                    k[i] = 0;
                    m_busy[i] = 1'b1;
                    push(i);
                end
            end else if (txd) begin
                if (k[i] == NUMS[i] - 1) begin
                    m_busy[i] = 1'b0;
                    m_wd[i] = 1'b1;
                end else begin
                    k[i]++;
                    push(i);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        start = 1'b0;
        tx_done = 1'b0;
        abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m_busy[i] = 1'b0;
            m_txe[i] = 1'b0;
            m_wd[i] = 1'b0;
            rd[i] = wr[i];
        end
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_data_out[%0d]", i), dout[i], 64'd0);
            check($sformatf("rst_tx_enable[%0d]", i), 64'(txe[i]), 64'd0);
            check($sformatf("rst_busy[%0d]", i), 64'(bsy[i]), 64'd0);
            check($sformatf("rst_word_done[%0d]", i), 64'(wdn[i]), 64'd0);
        end
        repeat (n) @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("busy[%0d]", i), 64'(bsy[i]), 64'(m_busy[i]));
            check($sformatf("word_done[%0d]", i), 64'(wdn[i]), 64'(m_wd[i]));
            check($sformatf("tx_enable[%0d]", i), 64'(txe[i]), 64'(m_txe[i]));
            if (txe[i]) begin
                log_q[i] = (log_q[i] << OWS[i]) | dout[i];
                check($sformatf("chunk_avail[%0d]", i), 64'(rd[i] < wr[i]), 64'd1);
                if (rd[i] < wr[i]) begin
                    check($sformatf("chunk[%0d]", i), dout[i], exp_mem[i][rd[i] % 64]);
                    rd[i]++;
                end
            end
        end
    end

    initial begin
        logic [63:0] w;
        @(negedge clk);
        do_reset(2);
        step(1'b1, 64'hbb941c2b7e1d731b, 32'hdeadbeef, 1'b0, 1'b0);
        for (int a = 0; a < 8; a++) begin
            for (int j = 0; j < 4; j++) begin
                if (a == 2 && j == 0)
                    step(1'b1, rnd64(), 32'h12345678, 1'b0, 1'b0);
                else
                    step(1'b0, rnd64(), $urandom, 1'b0, 1'b0);
            end
            step(1'b0, rnd64(), $urandom, 1'b1, 1'b0);
        end
        repeat (2) step(1'b0, rnd64(), $urandom, 1'b0, 1'b0);
        check("log_msb_first", log_q[0], 64'hbb941c2b7e1d731b);
        check("log_lsb_first", log_q[1], 64'h1b731d7e2b1c94bb);
        check("log_32_16_b2b", log_q[2], 64'hdeadbeef12345678);

        step(1'b1, rnd64(), $urandom, 1'b0, 1'b0);
        repeat (4) step(1'b0, rnd64(), $urandom, 1'b1, 1'b0);
        step(1'b1, rnd64(), $urandom, 1'b1, 1'b1);
        for (int j = 0; j < 4; j++) step(1'b0, rnd64(), $urandom, j[0], 1'b0);
        w = 64'h0123456789abcdef;
        step(1'b1, w, $urandom, 1'b0, 1'b0);
        repeat (8) begin
            step(1'b0, rnd64(), $urandom, 1'b0, 1'b0);
            step(1'b0, rnd64(), $urandom, 1'b1, 1'b0);
        end
        check("log_after_abort", log_q[0], w);

        step(1'b1, rnd64(), $urandom, 1'b0, 1'b0);
        repeat (2) step(1'b0, rnd64(), $urandom, 1'b1, 1'b0);
        do_reset(2);
        for (int j = 0; j < 6; j++) step(1'b0, rnd64(), $urandom, j[0], 1'b0);

        for (int n = 0; n < 3000; n++)
            step($urandom_range(0, 3) == 0, rnd64(), $urandom, $urandom_range(0, 2) == 0, $urandom_range(0, 63) == 0);
        repeat (2) step(1'b0, rnd64(), $urandom, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++)
            check($sformatf("drained[%0d]", i), 64'(rd[i]), 64'(wr[i]));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wide_to_narrow_serializer.md
WIDE_TO_NARROW_SERIALIZER -- requirements
Module: wide_to_narrow_serializer

Interface
REQ-001 The block SHALL have parameter IN_W, default 64, meaning the width of the parallel input word.
REQ-002 The block SHALL have parameter OUT_W, default 8, meaning the width of each output chunk.
REQ-003 The block SHALL have parameter MSB_FIRST, default 1; 1 means the most-significant chunk is sent first, 0 means the least-significant chunk is sent first.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset, as listed below.
REQ-005 clk  input  1  clock; all logic rising-edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 data_in  input  IN_W  parallel word, sampled only when a start is accepted.
REQ-008 start  input  1  request to serialise data_in; level sampled each cycle.
REQ-009 tx_done  input  1  downstream one-cycle acknowledge that the current chunk has been consumed (e.g. UART byte complete).
REQ-010 abort  input  1  synchronous cancel of the word in progress.
REQ-011 data_out  output  OUT_W  current chunk; registered.
REQ-012 tx_enable  output  1  one-cycle pulse: data_out holds a new chunk for the downstream transmitter; registered.
REQ-013 busy  output  1  high from start acceptance until the word completes or is aborted; registered.
REQ-014 word_done  output  1  one-cycle pulse after the last chunk is acknowledged; registered.

Function
REQ-015 NUM = IN_W/OUT_W; the block SHALL fail elaboration if IN_W mod OUT_W != 0 or NUM < 2.
REQ-016 Chunk counter width SHALL be $clog2(NUM); chunk k (k = 0..NUM-1) SHALL be captured[IN_W-1-k*OUT_W -: OUT_W] when MSB_FIRST=1, else captured[k*OUT_W +: OUT_W].
REQ-017 FSM states SHALL be IDLE and WAIT only.
REQ-018 IDLE, start=1 at an edge: capture data_in, set counter=0, data_out<=chunk 0, tx_enable<=1, busy<=1, go to WAIT; tx_enable SHALL be high in the cycle immediately following that edge.
REQ-019 IDLE, start=0: remain in IDLE; tx_enable, word_done low; data_out holds its last value.
REQ-020 WAIT, tx_done=0: hold; tx_enable SHALL be high only in the first cycle of each chunk.
REQ-021 WAIT, tx_done=1, counter<NUM-1: counter++, data_out<=next chunk, tx_enable<=1, remain in WAIT.
REQ-022 WAIT, tx_done=1, counter=NUM-1: word_done<=1 for one cycle, busy<=0, go to IDLE; data_out holds the last chunk.
REQ-023 start while busy=1 SHALL be ignored; data_in changes after capture SHALL NOT affect output.
REQ-024 tx_done in IDLE SHALL be ignored; tx_done coinciding with the tx_enable cycle SHALL be honoured as an acknowledgement.
REQ-025 start sampled in the cycle word_done is high (state IDLE) SHALL be accepted, giving back-to-back words with no idle gap beyond that cycle.
REQ-026 abort=1 at any edge SHALL force IDLE, busy<=0, tx_enable<=0, counter<=0; word_done SHALL NOT pulse; abort SHALL win over simultaneous tx_done and start.
REQ-027 Exactly NUM tx_enable pulses SHALL occur per non-aborted word.

Reset
REQ-028 While rst_n=0: state=IDLE, counter=0, capture register=0, data_out=0, tx_enable=0, busy=0, word_done=0, asynchronously.
REQ-029 Reset asserted mid-word SHALL discard the word; no word_done and no further tx_enable after release until a new start.
REQ-030 First start accepted SHALL be at the first rising edge with rst_n=1.

Verification
REQ-031 Defaults, data_in=64'hbb941c2b7e1d731b, start pulse, tx_done 5 cycles after each tx_enable -> data_out bb,94,1c,2b,7e,1d,73,1b, 8 tx_enable pulses, word_done once, busy low after.
REQ-032 MSB_FIRST=0, same word -> 1b,73,1d,7e,2b,1c,94,bb.
REQ-033 IN_W=32, OUT_W=16, data_in=32'hdeadbeef -> dead then beef; second start in word_done cycle with 32'h12345678 -> 1234, 5678 immediately following.
REQ-034 start and data_in change while busy after chunk 3 -> ignored; original word completes unchanged.
REQ-035 abort coinciding with tx_done after chunk 4 -> no more tx_enable, no word_done, busy=0 next cycle; new start then sends full word from chunk 0.
REQ-036 rst_n low for 2 cycles after chunk 2 -> all outputs 0 immediately; tx_done pulses after release produce no activity.
